// File: rtl/mem_pkg.sv
// Shared widths, boot FSM states and the MMIO address for the dual-issue memory responder.
// Pure declarations: no latency, no backpressure.
package mem_pkg;

  localparam int AW_DEFAULT = 9;
  localparam int DW_DEFAULT = 16;
  localparam logic [8:0] IO_ADDR_DEFAULT = 9'h1FF;

  typedef enum logic [1:0] {
    LOAD    = 2'd0,
    RELEASE = 2'd1,
    RUN     = 2'd2
  } boot_state_t;

endpackage

// File: rtl/mem_bank_2r1w.sv
// Word array with two registered read ports and two write ports; read-first, port 1 wins on collision.
// Latency 1 cycle; rd_en low holds both read registers, rd_clr forces them to zero.
module mem_bank_2r1w
  import mem_pkg::*;
#(
  parameter int AW = AW_DEFAULT,
  parameter int DW = DW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rd_en,
  input  logic          rd_clr,
  input  logic [AW-1:0] rd_addr0,
  input  logic [AW-1:0] rd_addr1,
  output logic [DW-1:0] rd_data0,
  output logic [DW-1:0] rd_data1,
  input  logic          wr_en0,
  input  logic [AW-1:0] wr_addr0,
  input  logic [DW-1:0] wr_data0,
  input  logic          wr_en1,
  input  logic [AW-1:0] wr_addr1,
  input  logic [DW-1:0] wr_data1
);

  logic [DW-1:0] mem [2**AW];

  // Port 1 is written last so it overrides port 0 on a same-address collision.
  always_ff @(posedge clk) begin
    if (wr_en0) mem[wr_addr0] <= wr_data0;
    if (wr_en1) mem[wr_addr1] <= wr_data1;
  end

  always_ff @(posedge clk) begin
    if (!rst || rd_clr) begin
      rd_data0 <= '0;
      rd_data1 <= '0;
    end else if (rd_en) begin
      rd_data0 <= mem[rd_addr0];
      rd_data1 <= mem[rd_addr1];
    end
  end

endmodule

// File: rtl/dual_mem_responder.sv
// DM/IM responder for the dual-issue core with a host boot loader and one MMIO output register.
// Latency 1 cycle on all reads; host is accepted only in LOAD, core held until RUN.
module dual_mem_responder
  import mem_pkg::*;
#(
  parameter int          AW      = AW_DEFAULT,
  parameter int          DW      = DW_DEFAULT,
  parameter logic [AW-1:0] IO_ADDR = IO_ADDR_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] p0_DM_maddr,
  input  logic [DW-1:0] p0_DM_wdata,
  input  logic          p0_DM_write_mem,
  output logic [DW-1:0] p0_DM_rdata,
  input  logic [AW-1:0] p1_DM_maddr,
  input  logic [DW-1:0] p1_DM_wdata,
  input  logic          p1_DM_write_mem,
  output logic [DW-1:0] p1_DM_rdata,
  input  logic [AW-1:0] p0_IM_maddr,
  input  logic [AW-1:0] p1_IM_maddr,
  input  logic          IM_ena,
  output logic [DW-1:0] p0_IM_rdata,
  output logic [DW-1:0] p1_IM_rdata,
  input  logic          load_valid,
  output logic          load_ready,
  input  logic          load_sel,
  input  logic [AW-1:0] load_addr,
  input  logic [DW-1:0] load_data,
  input  logic          load_done,
  output logic          cpu_hold,
  output logic [DW-1:0] io_out
);

  boot_state_t state, state_nxt;
  logic run;
  logic ld_fire;

  always_ff @(posedge clk) begin
    if (!rst) state <= LOAD;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    load_ready = 1'b0;
    cpu_hold   = 1'b1;
    run        = 1'b0;
    case (state)
      LOAD: begin
        load_ready = rst;
        if (load_done) state_nxt = RELEASE;
      end
      RELEASE: state_nxt = RUN;
      RUN: begin
        cpu_hold = !rst;
        run      = rst;
      end
      default: state_nxt = LOAD;
    endcase
  end

  assign ld_fire = load_valid && load_ready;

  // DM write port 0 belongs to the host loader until the core is released.
  logic          dm_we0;
  logic [AW-1:0] dm_wa0;
  logic [DW-1:0] dm_wd0;
  logic          dm_we1;

  assign dm_we0 = run ? p0_DM_write_mem : (ld_fire && load_sel);
  assign dm_wa0 = run ? p0_DM_maddr : load_addr;
  assign dm_wd0 = run ? p0_DM_wdata : load_data;
  assign dm_we1 = run && p1_DM_write_mem;

  mem_bank_2r1w #(.AW(AW), .DW(DW)) u_dm (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (1'b1),
    .rd_clr   (!run),
    .rd_addr0 (p0_DM_maddr),
    .rd_addr1 (p1_DM_maddr),
    .rd_data0 (p0_DM_rdata),
    .rd_data1 (p1_DM_rdata),
    .wr_en0   (dm_we0),
    .wr_addr0 (dm_wa0),
    .wr_data0 (dm_wd0),
    .wr_en1   (dm_we1),
    .wr_addr1 (p1_DM_maddr),
    .wr_data1 (p1_DM_wdata)
  );

  mem_bank_2r1w #(.AW(AW), .DW(DW)) u_im (
    .clk      (clk),
    .rst      (rst),
    .rd_en    (IM_ena),
    .rd_clr   (!run),
    .rd_addr0 (p0_IM_maddr),
    .rd_addr1 (p1_IM_maddr),
    .rd_data0 (p0_IM_rdata),
    .rd_data1 (p1_IM_rdata),
    .wr_en0   (ld_fire && !load_sel),
    .wr_addr0 (load_addr),
    .wr_data0 (load_data),
    .wr_en1   (1'b0),
    .wr_addr1 ('0),
    .wr_data1 ('0)
  );

  // MMIO mirrors the array's collision rule: pipe1 data wins.
  always_ff @(posedge clk) begin
    if (!rst) begin
      io_out <= '0;
    end else if (run) begin
      if (p1_DM_write_mem && p1_DM_maddr == IO_ADDR)      io_out <= p1_DM_wdata;
      else if (p0_DM_write_mem && p0_DM_maddr == IO_ADDR) io_out <= p0_DM_wdata;
    end
  end

endmodule

// File: tb/tb_dual_mem_responder.sv
// Directed bench for dual_mem_responder: boot, fetch stall, DM collisions, read-first, MMIO, load gating.
module tb_dual_mem_responder;
  import mem_pkg::*;

  localparam int AW = 9;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] p0_DM_maddr, p1_DM_maddr, p0_IM_maddr, p1_IM_maddr, load_addr;
  logic [DW-1:0] p0_DM_wdata, p1_DM_wdata, load_data;
  logic          p0_DM_write_mem, p1_DM_write_mem, IM_ena;
  logic          load_valid, load_sel, load_done;
  logic [DW-1:0] p0_DM_rdata, p1_DM_rdata, p0_IM_rdata, p1_IM_rdata, io_out;
  logic          load_ready, cpu_hold;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  dual_mem_responder #(.AW(AW), .DW(DW), .IO_ADDR(9'h1FF)) dut (
    .clk             (clk),
    .rst             (rst),
    .p0_DM_maddr     (p0_DM_maddr),
    .p0_DM_wdata     (p0_DM_wdata),
    .p0_DM_write_mem (p0_DM_write_mem),
    .p0_DM_rdata     (p0_DM_rdata),
    .p1_DM_maddr     (p1_DM_maddr),
    .p1_DM_wdata     (p1_DM_wdata),
    .p1_DM_write_mem (p1_DM_write_mem),
    .p1_DM_rdata     (p1_DM_rdata),
    .p0_IM_maddr     (p0_IM_maddr),
    .p1_IM_maddr     (p1_IM_maddr),
    .IM_ena          (IM_ena),
    .p0_IM_rdata     (p0_IM_rdata),
    .p1_IM_rdata     (p1_IM_rdata),
    .load_valid      (load_valid),
    .load_ready      (load_ready),
    .load_sel        (load_sel),
    .load_addr       (load_addr),
    .load_data       (load_data),
    .load_done       (load_done),
    .cpu_hold        (cpu_hold),
    .io_out          (io_out)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic host_word(input logic sel, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           input logic done);
    load_valid = 1'b1;
    load_sel   = sel;
    load_addr  = a;
    load_data  = d;
    load_done  = done;
    step();
    load_valid = 1'b0;
    load_done  = 1'b0;
  endtask

  logic [DW-1:0] im_img [4];

  initial begin
    im_img[0] = 16'h1111; im_img[1] = 16'h2222; im_img[2] = 16'h3333; im_img[3] = 16'h4444;
    rst = 1'b0;
    p0_DM_maddr = '0; p1_DM_maddr = '0; p0_IM_maddr = '0; p1_IM_maddr = '0;
    p0_DM_wdata = '0; p1_DM_wdata = '0; p0_DM_write_mem = 1'b0; p1_DM_write_mem = 1'b0;
    IM_ena = 1'b0; load_valid = 1'b0; load_sel = 1'b0; load_addr = '0; load_data = '0;
    load_done = 1'b0;

    step(); step();
    chk("rst_hold", cpu_hold, 1);
    chk("rst_ready", load_ready, 0);
    chk("rst_io", io_out, 0);
    chk("rst_dm0", p0_DM_rdata, 0);
    chk("rst_im1", p1_IM_rdata, 0);
    rst = 1'b1;
    #1;
    chk("load_ready", load_ready, 1);

    // Host DM image first, then core writes in LOAD must be dropped.
    host_word(1'b1, 9'd3, 16'h5A5A, 1'b0);
    host_word(1'b1, 9'd7, 16'h0001, 1'b0);
    p0_DM_write_mem = 1'b1; p0_DM_maddr = 9'd3; p0_DM_wdata = 16'hDEAD;
    p1_DM_write_mem = 1'b1; p1_DM_maddr = 9'd3; p1_DM_wdata = 16'hBEEF;
    step();
    p0_DM_write_mem = 1'b0; p1_DM_write_mem = 1'b0;
    chk("load_gate_rd0", p0_DM_rdata, 0);
    chk("load_gate_rd1", p1_DM_rdata, 0);

    for (int i = 0; i < 4; i++) host_word(1'b0, 9'(i), im_img[i], i == 3);
    chk("release_hold", cpu_hold, 1);
    chk("release_ready", load_ready, 0);
    step();
    chk("run_hold", cpu_hold, 0);

    IM_ena = 1'b1; p0_IM_maddr = 9'd0; p1_IM_maddr = 9'd1;
    step();
    chk("boot_im0", p0_IM_rdata, 16'h1111);
    chk("boot_im1", p1_IM_rdata, 16'h2222);

    IM_ena = 1'b0; p0_IM_maddr = 9'd2; p1_IM_maddr = 9'd3;
    step();
    chk("stall_im0", p0_IM_rdata, 16'h1111);
    chk("stall_im1", p1_IM_rdata, 16'h2222);
    IM_ena = 1'b1;
    step();
    chk("fetch_im0", p0_IM_rdata, 16'h3333);
    chk("fetch_im1", p1_IM_rdata, 16'h4444);

    p0_DM_maddr = 9'd3; p1_DM_maddr = 9'd3;
    step();
    chk("dm3_p0", p0_DM_rdata, 16'h5A5A);
    chk("dm3_p1", p1_DM_rdata, 16'h5A5A);

    p0_DM_write_mem = 1'b1; p0_DM_maddr = 9'd5; p0_DM_wdata = 16'hAAAA;
    p1_DM_write_mem = 1'b1; p1_DM_maddr = 9'd5; p1_DM_wdata = 16'hBBBB;
    step();
    p0_DM_write_mem = 1'b0; p1_DM_write_mem = 1'b0;
    step();
    chk("conflict_p0", p0_DM_rdata, 16'hBBBB);
    chk("conflict_p1", p1_DM_rdata, 16'hBBBB);

    p0_DM_write_mem = 1'b1; p0_DM_maddr = 9'd7; p0_DM_wdata = 16'h00FF;
    p1_DM_maddr = 9'd7;
    step();
    p0_DM_write_mem = 1'b0;
    chk("rdfirst_p1", p1_DM_rdata, 16'h0001);
    chk("rdfirst_p0", p0_DM_rdata, 16'h0001);
    step();
    chk("rdafter_p1", p1_DM_rdata, 16'h00FF);

    p1_DM_write_mem = 1'b1; p1_DM_maddr = 9'h1FF; p1_DM_wdata = 16'hC0DE;
    step();
    p1_DM_write_mem = 1'b0;
    chk("mmio_p1", io_out, 16'hC0DE);
    p0_DM_maddr = 9'h1FF;
    step();
    chk("mmio_arr", p0_DM_rdata, 16'hC0DE);

    p0_DM_write_mem = 1'b1; p0_DM_wdata = 16'h1234;
    p1_DM_write_mem = 1'b1; p1_DM_wdata = 16'h9876;
    step();
    p1_DM_write_mem = 1'b0;
    chk("mmio_dual", io_out, 16'h9876);
    p0_DM_wdata = 16'hC0DE;
    step();
    p0_DM_write_mem = 1'b0;
    chk("mmio_p0", io_out, 16'hC0DE);

    rst = 1'b0;
    step();
    chk("rerst_io", io_out, 0);
    chk("rerst_hold", cpu_hold, 1);
    chk("rerst_im0", p0_IM_rdata, 0);
    rst = 1'b1;
    #1;
    chk("rerst_ready", load_ready, 1);
    load_done = 1'b1;
    step();
    load_done = 1'b0;
    step();
    chk("rerun_hold", cpu_hold, 0);
    p0_DM_maddr = 9'h1FF; p0_IM_maddr = 9'd0; p1_IM_maddr = 9'd1;
    step();
    chk("retain_dm", p0_DM_rdata, 16'hC0DE);
    chk("retain_im1", p1_IM_rdata, 16'h2222);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
